// File: rtl/adc_trig_seq.sv
// ADC trigger sequencer: turns the synchronized trigger level into one capture
// window (edge detect -> delay -> window -> hold-off) and counts accepted/missed triggers.
module adc_trig_seq #(
    parameter int DLY_W = 8,
    parameter int LEN_W = 12,
    parameter int CNT_W = 16
) (
    input  logic             clk2,
    input  logic             rstb,
    input  logic             trig_s,
    input  logic             enable,
    input  logic [DLY_W-1:0] delay,
    input  logic [LEN_W-1:0] length,
    input  logic [DLY_W-1:0] holdoff,
    input  logic             clr_cnt,
    output logic             capture_en,
    output logic             capture_first,
    output logic             capture_last,
    output logic             busy,
    output logic [CNT_W-1:0] trig_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam int CW = (LEN_W > DLY_W) ? LEN_W : DLY_W;

    typedef enum logic [1:0] {IDLE, DELAY, CAPTURE, HOLDOFF} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [LEN_W-1:0] len_q;
    logic [DLY_W-1:0] ho_q;
    logic [LEN_W-1:0] len_m1;
    logic             trig_d;
    logic             rise, accept;
    logic             en_nxt, first_nxt, last_nxt, busy_nxt;

    assign rise   = trig_s & ~trig_d;
    assign accept = rise & enable & (state == IDLE);
    // Window length is stored minus one so that a length of 0 or 1 both give a single cycle.
    assign len_m1 = (length == '0) ? '0 : length - LEN_W'(1);

    // NOTE: every register here uses <= so all flops update from pre-edge values.
    always_ff @(posedge clk2 or negedge rstb) begin
        if (!rstb) begin
            state  <= IDLE;
            cnt    <= '0;
            len_q  <= '0;
            ho_q   <= '0;
            trig_d <= 1'b1;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            trig_d <= trig_s;
            if (accept) begin
                len_q <= len_m1;
                ho_q  <= holdoff;
            end
        end
    end

    // NOTE: defaults at the top of each always_comb keep it free of inferred latches.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (delay == '0) begin
                        state_nxt = CAPTURE;
                        cnt_nxt   = CW'(len_m1);
                    end else begin
                        state_nxt = DELAY;
                        cnt_nxt   = CW'(delay - DLY_W'(1));
                    end
                end
            end
            DELAY: begin
                if (cnt == '0) begin
                    state_nxt = CAPTURE;
                    cnt_nxt   = CW'(len_q);
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            CAPTURE: begin
                if (cnt == '0) begin
                    if (ho_q != '0) begin
                        state_nxt = HOLDOFF;
                        cnt_nxt   = CW'(ho_q - DLY_W'(1));
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            HOLDOFF: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the registered versions line up with it.
    always_comb begin
        en_nxt    = (state_nxt == CAPTURE);
        first_nxt = (state_nxt == CAPTURE) && (state != CAPTURE);
        last_nxt  = (state_nxt == CAPTURE) && (cnt_nxt == '0);
        busy_nxt  = (state_nxt != IDLE);
    end

    always_ff @(posedge clk2 or negedge rstb) begin
        if (!rstb) begin
            capture_en    <= 1'b0;
            capture_first <= 1'b0;
            capture_last  <= 1'b0;
            busy          <= 1'b0;
        end else begin
            capture_en    <= en_nxt;
            capture_first <= first_nxt;
            capture_last  <= last_nxt;
            busy          <= busy_nxt;
        end
    end

    // Clear wins over a simultaneous increment; both counters saturate at all-ones.
    always_ff @(posedge clk2 or negedge rstb) begin
        if (!rstb) begin
            trig_cnt <= '0;
            miss_cnt <= '0;
        end else if (clr_cnt) begin
            trig_cnt <= '0;
            miss_cnt <= '0;
        end else begin
            if (accept && (trig_cnt != '1)) trig_cnt <= trig_cnt + CNT_W'(1);
            if (rise && !accept && (miss_cnt != '1)) miss_cnt <= miss_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_adc_trig_seq.sv
// Self-checking bench for adc_trig_seq: expected capture windows are queued when a
// trigger is driven and matched against the windows the DUT actually produces.
module tb_adc_trig_seq;

    logic        clk2 = 1'b0;
    logic        rstb;
    logic        trig_s;
    logic        enable;
    logic [7:0]  delay;
    logic [11:0] length;
    logic [7:0]  holdoff;
    logic        clr_cnt;
    logic        capture_en, capture_first, capture_last, busy;
    logic [15:0] trig_cnt, miss_cnt;
    logic        s_en, s_first, s_last, s_busy;
    logic [3:0]  s_trig_cnt, s_miss_cnt;

    typedef struct {
        int start;
        int len;
    } win_t;

    win_t exp_q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_miss = 0;
    int   exp_trig = 0;
    int   exp_miss = 0;
    bit   in_win = 0;
    int   win_start, win_len;

    adc_trig_seq dut (
        .clk2(clk2), .rstb(rstb), .trig_s(trig_s), .enable(enable), .delay(delay),
        .length(length), .holdoff(holdoff), .clr_cnt(clr_cnt),
        .capture_en(capture_en), .capture_first(capture_first), .capture_last(capture_last),
        .busy(busy), .trig_cnt(trig_cnt), .miss_cnt(miss_cnt)
    );

    // Narrow-counter copy so saturation is reachable in a short run.
    adc_trig_seq #(.CNT_W(4)) dut_sat (
        .clk2(clk2), .rstb(rstb), .trig_s(trig_s), .enable(enable), .delay(delay),
        .length(length), .holdoff(holdoff), .clr_cnt(clr_cnt),
        .capture_en(s_en), .capture_first(s_first), .capture_last(s_last),
        .busy(s_busy), .trig_cnt(s_trig_cnt), .miss_cnt(s_miss_cnt)
    );

    always #5 clk2 = ~clk2;
    always @(posedge clk2) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk2);
            #1;
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk2);
            #1;
        end
    endtask

    // One-cycle trigger pulse; t is the cycle in which the rising edge is seen.
    task automatic pulse(output int t);
        @(posedge clk2);
        #1;
        trig_s = 1'b1;
        t = cyc;
        @(posedge clk2);
        #1;
        trig_s = 1'b0;
    endtask

    always @(negedge clk2) begin
        if (!rstb) begin
            in_win = 1'b0;
        end else if (capture_en) begin
            if (!in_win) begin
                in_win    = 1'b1;
                win_start = cyc;
                win_len   = 0;
                check("first_flag", capture_first, 1'b1);
            end else begin
                check("first_mid", capture_first, 1'b0);
            end
            win_len++;
            if (capture_last) begin
                in_win = 1'b0;
                if (exp_q.size() == 0) begin
                    check("unexpected_window", win_start, 32'hFFFF_FFFF);
                end else begin
                    win_t e;
                    e = exp_q.pop_front();
                    check("win_start", win_start, e.start);
                    check("win_len", win_len, e.len);
                end
            end
        end else if (in_win) begin
            in_win = 1'b0;
            check("last_missing", 1'b0, 1'b1);
        end
    end

    initial begin
        int t, t0;
        rstb = 1'b0; trig_s = 1'b1; enable = 1'b1; clr_cnt = 1'b0;
        delay = 8'd0; length = 12'd4; holdoff = 8'd0;

        // Reset with the trigger level already high: no edge on release.
        #23;
        check("rst_capture_en", capture_en, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_trig_cnt", trig_cnt, 16'd0);
        check("rst_miss_cnt", miss_cnt, 16'd0);
        @(posedge clk2);
        #1 rstb = 1'b1;
        wait_cycles(5);
        check("lvl_trig_cnt", trig_cnt, 16'd0);
        check("lvl_miss_cnt", miss_cnt, 16'd0);
        check("lvl_busy", busy, 1'b0);
        trig_s = 1'b0;
        wait_cycles(2);

        // Basic window.
        pulse(t);
        exp_q.push_back('{t + 1, 4});
        exp_trig++;
        check("basic_trig_cnt", trig_cnt, exp_trig);
        check("basic_busy_start", busy, 1'b1);
        wait_until(t + 4);
        check("basic_busy_end", busy, 1'b1);
        wait_until(t + 5);
        check("basic_busy_low", busy, 1'b0);

        // Delay and holdoff; inputs changed after accept must not matter.
        wait_cycles(2);
        delay = 8'd3; length = 12'd2; holdoff = 8'd5;
        pulse(t);
        exp_q.push_back('{t + 4, 2});
        exp_trig++;
        delay = 8'd0; length = 12'd7; holdoff = 8'd0;
        wait_until(t + 7);
        pulse(t0);
        check("holdoff_edge_cycle", t0, t + 8);
        exp_miss++;
        check("holdoff_miss_cnt", miss_cnt, exp_miss);
        wait_until(t + 10);
        check("holdoff_busy", busy, 1'b1);
        delay = 8'd3; length = 12'd2; holdoff = 8'd5;
        wait_until(t + 11);
        check("holdoff_busy_low", busy, 1'b0);
        pulse(t0);
        check("rearm_edge_cycle", t0, t + 12);
        exp_q.push_back('{t0 + 4, 2});
        exp_trig++;
        check("rearm_trig_cnt", trig_cnt, exp_trig);
        wait_until(t0 + 11);
        check("rearm_busy_low", busy, 1'b0);

        // Length zero behaves as a single cycle with first and last together.
        delay = 8'd0; length = 12'd0; holdoff = 8'd0;
        pulse(t);
        exp_q.push_back('{t + 1, 1});
        exp_trig++;
        wait_until(t + 2);
        check("len0_busy_low", busy, 1'b0);

        // Disabled: every edge is a miss, no window.
        enable = 1'b0;
        for (int i = 0; i < 3; i++) pulse(t);
        exp_miss += 3;
        wait_cycles(3);
        check("dis_trig_cnt", trig_cnt, exp_trig);
        check("dis_miss_cnt", miss_cnt, exp_miss);
        check("dis_busy", busy, 1'b0);
        enable = 1'b1;

        // Clear coincident with an accept.
        length = 12'd1;
        @(posedge clk2);
        #1;
        trig_s = 1'b1; clr_cnt = 1'b1; t = cyc;
        @(posedge clk2);
        #1;
        trig_s = 1'b0; clr_cnt = 1'b0;
        exp_q.push_back('{t + 1, 1});
        exp_trig = 0; exp_miss = 0;
        check("clr_trig_cnt", trig_cnt, 16'd0);
        check("clr_miss_cnt", miss_cnt, 16'd0);
        wait_cycles(2);

        // Back-to-back triggers drive the narrow counter into saturation.
        for (int i = 1; i <= 16; i++) begin
            pulse(t);
            exp_q.push_back('{t + 1, 1});
            exp_trig++;
            if (i >= 14) check("sat_trig_cnt", s_trig_cnt, (i > 15) ? 15 : i);
        end
        check("sat_main_trig_cnt", trig_cnt, exp_trig);
        check("sat_miss_cnt", s_miss_cnt, 4'd0);

        // Asynchronous reset in the middle of a long window.
        wait_cycles(2);
        length = 12'd100;
        pulse(t);
        exp_trig++;
        check("long_trig_cnt", trig_cnt, exp_trig);
        wait_until(t + 10);
        check("long_en_before_rst", capture_en, 1'b1);
        rstb = 1'b0;
        #1;
        check("arst_capture_en", capture_en, 1'b0);
        check("arst_first_last", {capture_first, capture_last}, 2'b00);
        check("arst_busy", busy, 1'b0);
        check("arst_trig_cnt", trig_cnt, 16'd0);
        exp_trig = 0; exp_miss = 0;
        wait_cycles(2);
        rstb = 1'b1;
        wait_cycles(2);
        check("post_rst_busy", busy, 1'b0);
        pulse(t);
        exp_q.push_back('{t + 1, 100});
        exp_trig++;
        check("post_rst_trig_cnt", trig_cnt, exp_trig);
        wait_until(t + 100);
        check("post_rst_busy_end", busy, 1'b1);
        wait_until(t + 101);
        check("post_rst_busy_low", busy, 1'b0);

        // Every queued window must have been seen.
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) wait_cycles(1);
        check("windows_pending", exp_q.size(), 0);
        check("final_miss_cnt", miss_cnt, exp_miss);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
